sram_mbist: RTL



---
 rtl/sram_mbist_pkg.sv | 51 +++++
 rtl/sram_mbist_if.sv | 34 +++
 rtl/sram_core.sv | 63 ++++++
 rtl/sram_mbist.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_mbist_pkg.sv
// Shared types for the MBIST-equipped SRAM: engine states, March C- element
// descriptors and data-background helpers.
package sram_mbist_pkg;

    localparam int MAX_DATA_W = 256;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_FLUSH = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // One March element: sweep direction, which ops it performs, and the
    // background expected on its read and written by its write.
    typedef struct packed {
        logic down;
        logic do_read;
        logic do_write;
        logic rd_bg;
        logic wr_bg;
    } march_elem_t;

    function automatic logic [MAX_DATA_W-1:0] background_0();
        return {MAX_DATA_W{1'b0}};
    endfunction

    function automatic logic [MAX_DATA_W-1:0] background_1(input int unsigned width);
        return {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - width);
    endfunction

    function automatic march_elem_t march_elem(input state_t st);
        march_elem_t e;
        case (st)
            ST_M0:   e = '{down: 1'b0, do_read: 1'b0, do_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0};
            ST_M1:   e = '{down: 1'b0, do_read: 1'b1, do_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
            ST_M2:   e = '{down: 1'b0, do_read: 1'b1, do_write: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
            ST_M3:   e = '{down: 1'b1, do_read: 1'b1, do_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
            ST_M4:   e = '{down: 1'b1, do_read: 1'b1, do_write: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
            ST_M5:   e = '{down: 1'b0, do_read: 1'b1, do_write: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
            default: e = '{down: 1'b0, do_read: 1'b0, do_write: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_mbist_if.sv
// User-facing bundle of the SRAM: functional access port, BIST control and
// status, and the test-only fault injection controls.
interface sram_mbist_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              bist_start;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [CNT_W-1:0]  fail_count;
    logic              inj_en;
    logic [ADDR_W-1:0] inj_addr;
    logic [BIT_W-1:0]  inj_bit;

    modport master (
        output en, we, addr, wdata, bist_start, inj_en, inj_addr, inj_bit,
        input  rdata, bist_busy, bist_done, bist_fail, fail_addr, fail_count
    );

    modport slave (
        input  en, we, addr, wdata, bist_start, inj_en, inj_addr, inj_bit,
        output rdata, bist_busy, bist_done, bist_fail, fail_addr, fail_count
    );
endinterface

// File: rtl/sram_core.sv
// Single-port synchronous RAM with registered read, out-of-range guard and a
// stuck-at-1 read injection mux that leaves the stored word untouched.
module sram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 32,
    parameter int BIT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [BIT_W-1:0]  inj_bit,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic [DATA_W-1:0] inj_mask_s;
    logic [DATA_W-1:0] rd_word_s;

    // Address decode, injection mask and read word selection
    always_comb begin
        idx_s      = addr[IDX_W-1:0];
        in_range_s = (32'(addr) < 32'(DEPTH));
        if (inj_en && (inj_addr == addr)) begin
            inj_mask_s = DATA_W'(1'b1) << inj_bit;
        end else begin
            inj_mask_s = {DATA_W{1'b0}};
        end
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s] | inj_mask_s;
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Array write; the contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (en && we && in_range_s) begin
            mem_r[idx_s] <= wdata;
        end
    end

    // Registered read port, holds when no read is issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            rdata_r <= rd_word_s;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sram_mbist.sv
// SRAM with an in-line March C- self-test engine; the engine owns the array
// while busy and reports pass/fail, first failing address and failure count.
module sram_mbist
    import sram_mbist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_mbist_if.slave bus
);
    localparam int                BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [ADDR_W-1:0] ADDR_FIRST = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] BG0        = DATA_W'(background_0());
    localparam logic [DATA_W-1:0] BG1        = DATA_W'(background_1(DATA_W));
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_next_s;
    march_elem_t       elem_s;
    march_elem_t       elem_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic              phase_r;
    logic              is_march_s;
    logic              op_read_s;
    logic              op_write_s;
    logic              last_op_s;
    logic              at_term_s;
    logic              start_s;
    logic [DATA_W-1:0] op_wdata_s;
    logic [DATA_W-1:0] op_exp_s;

    logic              core_en_s;
    logic              core_we_s;
    logic [ADDR_W-1:0] core_addr_s;
    logic [DATA_W-1:0] core_wdata_s;
    logic [DATA_W-1:0] rdata_s;

    logic              cmp_pend_r;
    logic [DATA_W-1:0] cmp_exp_r;
    logic [ADDR_W-1:0] cmp_addr_r;
    logic              busy_r;
    logic              done_r;
    logic              fail_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [CNT_W-1:0]  fail_count_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: elements advance after their last op at the terminal address
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                start_s = bus.bist_start;
                if (bus.bist_start) begin
                    state_next_s = ST_M0;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                if (last_op_s && at_term_s) begin
                    state_next_s = state_t'(state_r + 4'd1);
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_FLUSH: state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
        elem_next_s = march_elem(state_next_s);
    end

    // FSM outputs: decode the op issued this cycle
    always_comb begin
        elem_s = march_elem(state_r);
        case (state_r)
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: is_march_s = 1'b1;
            default:                                  is_march_s = 1'b0;
        endcase
        if (is_march_s) begin
            op_read_s  = elem_s.do_read && !phase_r;
            op_write_s = elem_s.do_write && !op_read_s;
        end else begin
            op_read_s  = 1'b0;
            op_write_s = 1'b0;
        end
        last_op_s  = !(elem_s.do_read && elem_s.do_write) || phase_r;
        at_term_s  = elem_s.down ? (addr_r == ADDR_FIRST) : (addr_r == ADDR_LAST);
        op_wdata_s = elem_s.wr_bg ? BG1 : BG0;
        op_exp_s   = elem_s.rd_bg ? BG1 : BG0;
    end

    // Address/phase counter; reloaded on element entry, never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= ADDR_FIRST;
            phase_r <= 1'b0;
        end else if ((state_next_s != state_r) && (state_next_s inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5})) begin
            addr_r  <= elem_next_s.down ? ADDR_LAST : ADDR_FIRST;
            phase_r <= 1'b0;
        end else if (is_march_s) begin
            if (!last_op_s) begin
                phase_r <= 1'b1;
            end else if (!at_term_s) begin
                phase_r <= 1'b0;
                addr_r  <= elem_s.down ? (addr_r - ADDR_W'(1)) : (addr_r + ADDR_W'(1));
            end else begin
                phase_r <= 1'b0;
            end
        end
    end

    // Port mux: engine while marching, user port only when not busy
    always_comb begin
        if (is_march_s) begin
            core_en_s    = op_read_s || op_write_s;
            core_we_s    = op_write_s;
            core_addr_s  = addr_r;
            core_wdata_s = op_wdata_s;
        end else if (!busy_r) begin
            core_en_s    = bus.en;
            core_we_s    = bus.we;
            core_addr_s  = bus.addr;
            core_wdata_s = bus.wdata;
        end else begin
            core_en_s    = 1'b0;
            core_we_s    = 1'b0;
            core_addr_s  = ADDR_FIRST;
            core_wdata_s = BG0;
        end
    end

    sram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BIT_W  (BIT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (core_en_s),
        .we       (core_we_s),
        .addr     (core_addr_s),
        .wdata    (core_wdata_s),
        .inj_en   (bus.inj_en),
        .inj_addr (bus.inj_addr),
        .inj_bit  (bus.inj_bit),
        .rdata    (rdata_s)
    );

    // Comparator: checks read data the cycle after issue, keeps first failing address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_pend_r   <= 1'b0;
            cmp_exp_r    <= BG0;
            cmp_addr_r   <= ADDR_FIRST;
            fail_r       <= 1'b0;
            fail_addr_r  <= ADDR_FIRST;
            fail_count_r <= {CNT_W{1'b0}};
        end else begin
            cmp_pend_r <= op_read_s;
            cmp_exp_r  <= op_exp_s;
            cmp_addr_r <= addr_r;
            if (start_s) begin
                fail_r       <= 1'b0;
                fail_addr_r  <= ADDR_FIRST;
                fail_count_r <= {CNT_W{1'b0}};
            end else if (cmp_pend_r && (rdata_s != cmp_exp_r)) begin
                if (fail_count_r != CNT_MAX) begin
                    fail_count_r <= fail_count_r + CNT_W'(1);
                end
                if (!fail_r) begin
                    fail_r      <= 1'b1;
                    fail_addr_r <= cmp_addr_r;
                end
            end
        end
    end

    // Status flags: busy spans start edge through the edge done rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_FLUSH})
                      || (state_r == ST_FLUSH);
            done_r <= (state_r == ST_DONE) && (state_next_s == ST_DONE);
        end
    end

    assign bus.rdata      = rdata_s;
    assign bus.bist_busy  = busy_r;
    assign bus.bist_done  = done_r;
    assign bus.bist_fail  = fail_r;
    assign bus.fail_addr  = fail_addr_r;
    assign bus.fail_count = fail_count_r;

endmodule
